// File: rtl/bidir_pad_sequencer.sv
// Two-requester serial transfer sequencer for one bidirectional IO pad.
// Define IN_REG_EN to register pad_i before the shift register (read XFER +1 cycle).
module bidir_pad_sequencer #(
    parameter int DATA_W   = 8,
    parameter int TURN_CYC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    input  logic [1:0]          wr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          done,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy,
    output logic                pad_o,
    output logic                pad_t,
    input  logic                pad_i
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] WLAST = CW'(DATA_W - 1);
`ifdef IN_REG_EN
    localparam logic [CW-1:0] RLAST = CW'(DATA_W);
`else
    localparam logic [CW-1:0] RLAST = CW'(DATA_W - 1);
`endif
    localparam logic [3:0] TLAST = 4'(TURN_CYC - 1);

    typedef enum logic [1:0] {IDLE, TURN, XFER, DONE} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              dir_q, dir_d;
    logic              last_dir_q, last_dir_d;
    logic              rr_q, rr_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CW-1:0]     bcnt_q, bcnt_d;
    logic [3:0]        tcnt_q, tcnt_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              busy_q, busy_d;
    logic              pad_o_q, pad_o_d;
    logic              pad_t_q, pad_t_d;
    logic              pad_in;
    logic              sample;

`ifdef IN_REG_EN
    logic pad_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pad_q <= 1'b0;
        else        pad_q <= pad_i;
    end

    // First read XFER cycle only primes the input flop.
    assign pad_in = pad_q;
    assign sample = (bcnt_q != '0);
`else
    assign pad_in = pad_i;
    assign sample = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            dir_q      <= 1'b0;
            last_dir_q <= 1'b0;
            rr_q       <= 1'b0;
            shift_q    <= '0;
            rdata_q    <= '0;
            bcnt_q     <= '0;
            tcnt_q     <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            pad_o_q    <= 1'b0;
            pad_t_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            dir_q      <= dir_d;
            last_dir_q <= last_dir_d;
            rr_q       <= rr_d;
            shift_q    <= shift_d;
            rdata_q    <= rdata_d;
            bcnt_q     <= bcnt_d;
            tcnt_q     <= tcnt_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            pad_o_q    <= pad_o_d;
            pad_t_q    <= pad_t_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        dir_d      = dir_q;
        last_dir_d = last_dir_q;
        rr_d       = rr_q;
        shift_d    = shift_q;
        rdata_d    = rdata_q;
        bcnt_d     = bcnt_q;
        tcnt_d     = tcnt_q;
        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    owner_d = (req == 2'b11) ? rr_q : req[1];
                    rr_d    = ~owner_d;
                    dir_d   = wr[owner_d];
                    shift_d = owner_d ? wdata[2*DATA_W-1:DATA_W]
                                      : wdata[DATA_W-1:0];
                    bcnt_d  = '0;
                    tcnt_d  = '0;
                    if (dir_d != last_dir_q && TURN_CYC > 0) state_d = TURN;
                    else                                     state_d = XFER;
                end
            end
            TURN: begin
                if (tcnt_q == TLAST) state_d = XFER;
                else                 tcnt_d  = tcnt_q + 4'd1;
            end
            XFER: begin
                // Writes drain LSB first; reads fill from the top.
                if (dir_q) begin
                    shift_d = shift_q >> 1;
                end else if (sample) begin
                    shift_d = shift_q >> 1;
                    shift_d[DATA_W-1] = pad_in;
                end
                if (bcnt_q == (dir_q ? WLAST : RLAST)) begin
                    state_d = DONE;
                    if (!dir_q) rdata_d = shift_d;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            DONE: begin
                last_dir_d = dir_q;
                state_d    = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_d  = '0;
        done_d = '0;
        if (state_q == IDLE && state_d != IDLE) gnt_d[owner_d] = 1'b1;
        if (state_d == DONE) done_d[owner_q] = 1'b1;
        busy_d  = (state_d != IDLE);
        pad_t_d = !(state_d == XFER && dir_d);
        pad_o_d = (state_d == XFER && dir_d) ? shift_d[0] : 1'b0;
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign pad_o = pad_o_q;
    assign pad_t = pad_t_q;

endmodule

// File: tb/tb_bidir_pad_sequencer.sv
// Bench for bidir_pad_sequencer: transaction-level timeline model plus
// directed scenarios (write, reads, contention, async reset mid-write).
module tb_bidir_pad_sequencer;

    localparam int DW = 8;
    localparam int TC = 2;
`ifdef IN_REG_EN
    localparam int RX = DW + 1;
`else
    localparam int RX = DW;
`endif
    localparam int MAXC = 256;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req;
    logic [1:0]      wr;
    logic [2*DW-1:0] wdata;
    logic [1:0]      gnt;
    logic [1:0]      done;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic            pad_o;
    logic            pad_t;
    logic            pad_i;

    bidir_pad_sequencer #(.DATA_W(DW), .TURN_CYC(TC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .wr    (wr),
        .wdata (wdata),
        .gnt   (gnt),
        .done  (done),
        .rdata (rdata),
        .busy  (busy),
        .pad_o (pad_o),
        .pad_t (pad_t),
        .pad_i (pad_i)
    );

    always #5 clk = ~clk;

    int tick = 0;
    int base = 0;
    always @(posedge clk) tick <= tick + 1;

    int tests = 0;
    int fails = 0;
    int cmp_c;
    int phase = 0;

    // Expected-output timeline, one slot per cycle since reset release
    logic [1:0]    exp_gnt [MAXC];
    logic [1:0]    exp_done[MAXC];
    logic          exp_busy[MAXC];
    logic          exp_padt[MAXC];
    logic          exp_pado[MAXC];
    logic          rd_load [MAXC];
    logic [DW-1:0] rd_val  [MAXC];
    logic          padv    [MAXC];
    logic [DW-1:0] m_rdata;
    logic          m_rr;
    logic          m_last;
    int            free_at;
    int            gidx;
    int            ord[6] = '{1, 2, 1, 2, 1, 2};
    logic          cnt_done = 1'b0;
    logic [DW-1:0] rsrc[2];
    logic [DW-1:0] lit_a5 = 8'hA5;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cmp_c, act, want);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < MAXC; i++) begin
            exp_gnt[i]  = 2'b00;
            exp_done[i] = 2'b00;
            exp_busy[i] = 1'b0;
            exp_padt[i] = 1'b1;
            exp_pado[i] = 1'b0;
            rd_load[i]  = 1'b0;
            rd_val[i]   = '0;
            padv[i]     = 1'($urandom);
        end
        m_rdata = '0;
        m_rr    = 1'b0;
        m_last  = 1'b0;
        free_at = 0;
        gidx    = 0;
    endtask

    always @(negedge clk or negedge rst_n) begin
        int c, g, t, x, d, sh;
        logic own, dir;
        logic [DW-1:0] word;
        #1;
        if (!rst_n) begin
            cmp_c = -1;
            chk("rst_pad_t", 32'(pad_t), 32'(1));
            chk("rst_pad_o", 32'(pad_o), 32'(0));
            chk("rst_gnt",   32'(gnt),   32'(0));
            chk("rst_done",  32'(done),  32'(0));
            chk("rst_busy",  32'(busy),  32'(0));
            chk("rst_rdata", 32'(rdata), 32'(0));
            model_clear();
        end else begin
            c = tick - base;
            cmp_c = c;
            if (c >= 0 && c < MAXC) begin
                if (rd_load[c]) m_rdata = rd_val[c];
                chk("gnt",   32'(gnt),   32'(exp_gnt[c]));
                chk("done",  32'(done),  32'(exp_done[c]));
                chk("busy",  32'(busy),  32'(exp_busy[c]));
                chk("pad_t", 32'(pad_t), 32'(exp_padt[c]));
                chk("pad_o", 32'(pad_o), 32'(exp_pado[c]));
                chk("rdata", 32'(rdata), 32'(m_rdata));

                case (phase)
                    1: begin
                        if (c == 1) chk("p1_gnt", 32'(gnt), 32'(1));
                        if (c == 2) chk("p1_turn", 32'(pad_t), 32'(1));
                        if (c >= 3 && c <= 10) begin
                            sh = c - 3;
                            chk("p1_padt", 32'(pad_t), 32'(0));
                            chk("p1_pado", 32'(pad_o), 32'((lit_a5 >> sh) & 8'h01));
                        end
                        if (c == 11) chk("p1_wdone", 32'(done), 32'(1));
                        if (c == 15 + RX) begin
                            chk("p1_rdone", 32'(done), 32'(2));
                            chk("p1_rdata", 32'(rdata), 32'h3C);
                        end
                        if (c == 17 + RX) chk("p1_rgnt2", 32'(gnt), 32'(2));
                        if (c == 17 + 2*RX) begin
                            chk("p1_rdone2", 32'(done), 32'(2));
                            chk("p1_rdata2", 32'(rdata), 32'h5B);
                        end
                    end
                    2: begin
                        if (c == 1) chk("p2_gnt0", 32'(gnt), 32'(1));
                        if (c == 3 + RX) chk("p2_gnt1", 32'(gnt), 32'(2));
                        if (gnt != 2'b00 && gidx < 6) begin
                            chk("p2_order", 32'(gnt), 32'(ord[gidx]));
                            gidx++;
                        end
                    end
                    21: begin
                        if (!cnt_done) begin
                            chk("p2_count", 32'(gidx), 32'(6));
                            cnt_done = 1'b1;
                        end
                    end
                    3: begin
                        if (c == 1 + RX) chk("p3_rdata", 32'(rdata), 32'h81);
                    end
                    4: begin
                        if (c == 1) chk("p4_gnt", 32'(gnt), 32'(1));
                        if (c == 2) chk("p4_turn", 32'(pad_t), 32'(1));
                        if (c == 3) chk("p4_drive", 32'(pad_t), 32'(0));
                        if (c == 11) chk("p4_done", 32'(done), 32'(1));
                    end
                    default: ;
                endcase

                // Arbitration and scheduling of the next transfer
                if (c >= free_at && req != 2'b00) begin
                    own  = (req == 2'b11) ? m_rr : (req == 2'b10);
                    m_rr = !own;
                    dir  = wr[own];
                    g    = c + 1;
                    t    = (dir != m_last && TC > 0) ? TC : 0;
                    x    = dir ? DW : RX;
                    d    = g + t + x;
                    if (d < MAXC) begin
                        exp_gnt[g]  = own ? 2'b10 : 2'b01;
                        exp_done[d] = own ? 2'b10 : 2'b01;
                        for (int i = g; i <= d; i++) exp_busy[i] = 1'b1;
                        if (dir) begin
                            word = own ? wdata[2*DW-1:DW] : wdata[DW-1:0];
                            for (int k = 0; k < DW; k++) begin
                                exp_padt[g+t+k] = 1'b0;
                                exp_pado[g+t+k] = word[k];
                            end
                        end else begin
                            word = rsrc[own];
                            for (int k = 0; k < DW; k++) padv[g+t+k] = word[k];
                            rd_load[d] = 1'b1;
                            rd_val[d]  = word;
                        end
                    end
                    m_last  = dir;
                    free_at = d + 1;
                end
            end
        end
    end

    int   cur = 0;
    int   gcnt = 0;
    logic auto_drop = 1'b1;

    task automatic step();
        @(posedge clk);
        #1;
        cur = tick - base;
        if (cur >= 0 && cur < MAXC) pad_i = padv[cur];
        if (gnt != 2'b00) begin
            gcnt++;
            if (auto_drop) req = req & ~gnt;
        end
    endtask

    task automatic hold_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        req   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        rst_n = 1'b1;
        base  = tick;
        cur   = 0;
        pad_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cur);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        req   = 2'b00;
        wr    = 2'b00;
        wdata = '0;
        pad_i = 1'b0;
        rsrc[0] = '0;
        rsrc[1] = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Write A5, then two reads on requester 1
        req = 2'b01; wr = 2'b01; wdata = {8'h00, 8'hA5};
        phase = 1;
        release_rst();
        while (cur < 12) step();
        req = 2'b10; wr = 2'b00; rsrc[1] = 8'h3C;
        while (cur < 20) step();
        req = 2'b10; rsrc[1] = 8'h5B;
        while (cur < 22 + 2*RX) step();

        // Contention, with a lone req[1] grant in the middle
        hold_reset();
        req = 2'b11; wr = 2'b10; wdata = {8'h69, 8'h00};
        rsrc[0] = 8'hE1; rsrc[1] = 8'h00;
        auto_drop = 1'b0; gcnt = 0; phase = 2;
        release_rst();
        for (int i = 0; i < 200 && gcnt < 3; i++) step();
        req = 2'b10; auto_drop = 1'b1;
        for (int i = 0; i < 200 && gcnt < 4; i++) step();
        req = 2'b11; auto_drop = 1'b0;
        for (int i = 0; i < 200 && gcnt < 6; i++) step();
        req = 2'b00;
        repeat (25) step();
        phase = 21;
        step();
        step();

        // Read, then write cut by async reset in XFER cycle 4
        hold_reset();
        req = 2'b01; wr = 2'b00; rsrc[0] = 8'h81;
        auto_drop = 1'b1; phase = 3;
        release_rst();
        while (cur < 2 + RX) step();
        req = 2'b01; wr = 2'b01; wdata = {8'h00, 8'hC3};
        while (cur < 9 + RX) step();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        req   = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // Fresh write after reset sees turnaround again
        req = 2'b01; wr = 2'b01; wdata = {8'h00, 8'h3A};
        phase = 4;
        release_rst();
        while (cur < 14) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
